// File: rtl/ysyx_22040632_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package ysyx_22040632_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam int W32 = 32;

   function automatic int cnt_w(input int xlen);
      return $clog2(xlen + 1);
   endfunction

endpackage

// File: rtl/ysyx_22040632_div_signfix.sv
// Operand conditioning before the iteration and sign/width fixup after it.
module ysyx_22040632_div_signfix
   import ysyx_22040632_div_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            pre_w,
   input  logic            div_signed,
   output logic [XLEN-1:0] a_ext,
   output logic [XLEN-1:0] b_ext,
   output logic [XLEN-1:0] a_wid,
   output logic [XLEN-1:0] a_mag,
   output logic [XLEN-1:0] b_mag,
   output logic            a_neg,
   output logic            b_neg,
   input  logic [XLEN-1:0] q_raw,
   input  logic [XLEN-1:0] r_raw,
   input  logic            q_neg,
   input  logic            r_neg,
   input  logic            post_w,
   output logic [XLEN-1:0] q_fix,
   output logic [XLEN-1:0] r_fix
);

   logic [XLEN-1:0] q_tmp;
   logic [XLEN-1:0] r_tmp;

   function automatic logic [XLEN-1:0] ext32(input logic [W32-1:0] v, input logic sgn);
      logic signed [XLEN-1:0] t;
      t = XLEN'(v);
      if (sgn) t = (t <<< (XLEN - W32)) >>> (XLEN - W32);
      return t;
   endfunction

   always_comb begin
      a_ext = pre_w ? ext32(dividend[W32-1:0], div_signed) : dividend;
      b_ext = pre_w ? ext32(divisor[W32-1:0], div_signed) : divisor;
      // Special-case results always sign-extend the low word, even for unsigned ops.
      a_wid = pre_w ? ext32(dividend[W32-1:0], 1'b1) : dividend;
      a_neg = div_signed & a_ext[XLEN-1];
      b_neg = div_signed & b_ext[XLEN-1];
      a_mag = a_neg ? -a_ext : a_ext;
      b_mag = b_neg ? -b_ext : b_ext;
      q_tmp = q_neg ? -q_raw : q_raw;
      r_tmp = r_neg ? -r_raw : r_raw;
      q_fix = post_w ? ext32(q_tmp[W32-1:0], 1'b1) : q_tmp;
      r_fix = post_w ? ext32(r_tmp[W32-1:0], 1'b1) : r_tmp;
   end

endmodule

// File: rtl/ysyx_22040632_divider_seq.sv
// Radix-2 restoring divider, one quotient bit per cycle, with RISC-V
// divide-by-zero / overflow shortcuts, flush and result backpressure.
module ysyx_22040632_divider_seq
   import ysyx_22040632_div_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            div_valid,
   input  logic            divw,
   input  logic            div_signed,
   input  logic            flush,
   input  logic            out_ready,
   output logic            div_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CW   = cnt_w(XLEN);
   localparam bit WIDE = (XLEN > W32);

   state_t          state, state_nx;
   logic            divw_eff, accept, div0, ovf, special;
   logic [XLEN-1:0] a_ext, b_ext, a_wid, a_mag, b_mag, q_fix, r_fix, min_w;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_sh, b_r, rem, q_next, r_next;
   logic [XLEN:0]   shifted, trial;
   logic [CW-1:0]   cnt;
   logic            q_neg, r_neg, divw_r;

   assign divw_eff = WIDE & divw;

   ysyx_22040632_div_signfix #(.XLEN(XLEN)) u_signfix (
      .dividend  (dividend),
      .divisor   (divisor),
      .pre_w     (divw_eff),
      .div_signed(div_signed),
      .a_ext     (a_ext),
      .b_ext     (b_ext),
      .a_wid     (a_wid),
      .a_mag     (a_mag),
      .b_mag     (b_mag),
      .a_neg     (a_neg),
      .b_neg     (b_neg),
      .q_raw     (q_next),
      .r_raw     (r_next),
      .q_neg     (q_neg),
      .r_neg     (r_neg),
      .post_w    (divw_r),
      .q_fix     (q_fix),
      .r_fix     (r_fix)
   );

   always_comb begin
      min_w   = divw_eff ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
      div0    = (b_ext == '0);
      ovf     = div_signed & (a_ext == min_w) & (&b_ext);
      special = div0 | ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (div_valid) state_nx = special ? DONE : BUSY;
            BUSY:    if (cnt == '0) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      div_ready = (state == IDLE);
      out_valid = (state == DONE);
      accept    = (state == IDLE) & div_valid & ~flush;
   end

   // The dividend register shifts out its MSB and collects quotient bits at the bottom.
   always_comb begin
      shifted = {rem, a_sh[XLEN-1]};
      trial   = shifted - {1'b0, b_r};
      if (trial[XLEN]) begin
         r_next = shifted[XLEN-1:0];
         q_next = {a_sh[XLEN-2:0], 1'b0};
      end else begin
         r_next = trial[XLEN-1:0];
         q_next = {a_sh[XLEN-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
      end else if (accept) begin
         // A 32-bit op is pre-aligned to the top so only 32 iterations are needed.
         a_sh   <= divw_eff ? (a_mag << W32) : a_mag;
         b_r    <= b_mag;
         rem    <= '0;
         cnt    <= divw_eff ? CW'(W32 - 1) : CW'(XLEN - 1);
         q_neg  <= a_neg ^ b_neg;
         r_neg  <= a_neg;
         divw_r <= divw_eff;
         if (div0) begin
            quotient  <= '1;
            remainder <= a_wid;
         end else if (ovf) begin
            quotient  <= a_wid;
            remainder <= '0;
         end
      end else if (state == BUSY) begin
         a_sh <= q_next;
         rem  <= r_next;
         cnt  <= cnt - CW'(1);
         if (cnt == '0) begin
            quotient  <= q_fix;
            remainder <= r_fix;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040632_divider_seq.sv
// Randomized and directed checks of the sequential divider against an arithmetic model.
module tb_ysyx_22040632_divider_seq;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] dividend, divisor;
   logic            div_valid, divw, div_signed, flush, out_ready;
   logic            div_ready, out_valid;
   logic [XLEN-1:0] quotient, remainder;

   int n_cmp = 0;
   int n_err = 0;

   ysyx_22040632_divider_seq #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .dividend  (dividend),
      .divisor   (divisor),
      .div_valid (div_valid),
      .divw      (divw),
      .div_signed(div_signed),
      .flush     (flush),
      .out_ready (out_ready),
      .div_ready (div_ready),
      .out_valid (out_valid),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // RISC-V DIV/DIVU/REM/REMU and their W forms, from plain arithmetic.
   function automatic void model(input logic [63:0] a, input logic [63:0] b, input bit w,
                                 input bit s, output logic [63:0] q, output logic [63:0] r,
                                 output bit sp);
      logic [31:0] a32, b32, q32, r32;
      int          sa, sb;
      longint      la, lb;
      a32 = a[31:0];
      b32 = b[31:0];
      sp  = 1'b0;
      if (w) begin
         if (b32 == 32'd0) begin
            q = '1; r = sx(a32); sp = 1'b1;
         end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q = sx(a32); r = 64'd0; sp = 1'b1;
         end else if (s) begin
            sa = a32; sb = b32;
            q32 = sa / sb; r32 = sa % sb;
            q = sx(q32); r = sx(r32);
         end else begin
            q32 = a32 / b32; r32 = a32 % b32;
            q = sx(q32); r = sx(r32);
         end
      end else begin
         if (b == 64'd0) begin
            q = '1; r = a; sp = 1'b1;
         end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = 64'd0; sp = 1'b1;
         end else if (s) begin
            la = a; lb = b;
            q = la / lb; r = la % lb;
         end else begin
            q = a / b; r = a % b;
         end
      end
   endfunction

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s);
      int g = 0;
      while (!div_ready && g < 200) begin
         step();
         g++;
      end
      chk("ready_before_issue", 64'(div_ready), 64'd1);
      dividend   = a;
      divisor    = b;
      divw       = w;
      div_signed = s;
      div_valid  = 1'b1;
      step();
      div_valid  = 1'b0;
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s,
                         input int hold, input bit stuff_req);
      logic [63:0] eq, er, q0, r0;
      bit          sp;
      int          lat;
      model(a, b, w, s, eq, er, sp);
      issue(a, b, w, s);
      chk("ready_after_accept", 64'(div_ready), 64'd0);
      lat = 1;
      while (!out_valid && lat < 200) begin
         step();
         lat++;
      end
      chk("latency", 64'(lat), sp ? 64'd1 : (w ? 64'd33 : 64'd65));
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      q0 = quotient;
      r0 = remainder;
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_quotient", quotient, q0);
         chk("hold_remainder", remainder, r0);
         chk("hold_ready", 64'(div_ready), 64'd0);
      end
      out_ready = 1'b1;
      if (stuff_req) begin
         dividend  = 64'd99;
         divisor   = 64'd9;
         div_valid = 1'b1;
      end
      step();
      out_ready = 1'b0;
      div_valid = 1'b0;
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("drain_ready", 64'(div_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] a, b;
      bit          w, s, seen;
      rst = 1'b1;
      dividend = '0; divisor = '0;
      div_valid = 1'b0; divw = 1'b0; div_signed = 1'b0;
      flush = 1'b0; out_ready = 1'b0;
      step();
      step();
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_ready", 64'(div_ready), 64'd1);
      chk("reset_quotient", quotient, 64'd0);
      chk("reset_remainder", remainder, 64'd0);
      rst = 1'b0;

      run_op(64'd100, 64'd7, 1'b0, 1'b0, 0, 1'b0);
      run_op(-64'sd7, 64'd2, 1'b0, 1'b1, 0, 1'b0);
      run_op(64'd7, -64'sd2, 1'b0, 1'b1, 0, 1'b0);
      run_op(64'h1234, 64'd0, 1'b0, 1'b0, 0, 1'b0);
      run_op(64'h8000_0000_0000_0000, '1, 1'b0, 1'b1, 0, 1'b0);
      run_op(64'hDEAD_BEEF_8000_0000, 64'd2, 1'b1, 1'b0, 0, 1'b0);
      run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 0, 1'b0);

      issue(64'd100, 64'd7, 1'b0, 1'b0);
      repeat (10) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_ready", 64'(div_ready), 64'd1);
      chk("flush_valid", 64'(out_valid), 64'd0);
      seen = 1'b0;
      repeat (80) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      chk("flush_no_result", 64'(seen), 64'd0);
      run_op(64'd50, 64'd5, 1'b0, 1'b0, 0, 1'b0);

      div_valid = 1'b1;
      flush     = 1'b1;
      step();
      div_valid = 1'b0;
      flush     = 1'b0;
      chk("flush_blocks_accept", 64'(div_ready), 64'd1);

      run_op(64'd1000, 64'd33, 1'b0, 1'b0, 5, 1'b1);

      issue(64'd100, 64'd7, 1'b0, 1'b0);
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_busy_valid", 64'(out_valid), 64'd0);
      chk("rst_busy_ready", 64'(div_ready), 64'd1);
      chk("rst_busy_quotient", quotient, 64'd0);

      for (int k = 0; k < 30; k++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         w = 1'($urandom % 2);
         s = 1'($urandom % 2);
         case ($urandom % 8)
            0: b = 64'd0;
            1: begin
               a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
               b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
            end
            2: b = {$urandom, 32'd0} | 64'($urandom % 16);
            3: b = 64'($urandom % 1000) + 64'd1;
            default: ;
         endcase
         run_op(a, b, w, s, int'($urandom % 4), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_22040632_divider_seq.md
Name: ysyx_22040632_divider_seq

Overview:
Multi-cycle radix-2 restoring integer divider for the EXU, implementing the divider side of the existing divider handshake bundle. It is parametrised in XLEN and supports 32-bit (divw) and signed modes. It adds RISC-V divide-by-zero and overflow semantics, early completion for special cases, and result backpressure via out_ready. Pipeline flush cancels any in-flight division.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64. With XLEN=32, divw is ignored (treated as 0).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
dividend  input  XLEN  dividend
divisor  input  XLEN  divisor
div_valid  input  1  request valid
divw  input  1  1 = 32-bit op on low 32 bits, result sign-extended to XLEN
div_signed  input  1  1 = signed division
flush  input  1  cancel current operation, return to idle
out_ready  input  1  consumer accepts result
div_ready  output  1  divider idle, request may be issued
out_valid  output  1  quotient/remainder valid
quotient  output  XLEN  quotient
remainder  output  XLEN  remainder

Behaviour:
- Reset (rst high at a clk edge): state IDLE; out_valid=0; quotient=0; remainder=0; div_ready=1 in the following cycle. rst overrides flush and div_valid.
- States:
  - IDLE: div_ready=1. Accept when div_valid=1 and flush=0. On accept, latch operands and mode, then go to BUSY, or to DONE for special cases.
  - BUSY: one quotient bit per cycle. N = 32 iterations if divw, else XLEN. Go to DONE after the N-th iteration.
  - DONE: out_valid=1; quotient/remainder held stable. Go to IDLE when out_ready=1.
- div_ready = (state==IDLE). Requests are never accepted in BUSY or DONE.
- Latency: accept edge T; normal result has out_valid high from cycle T+N+1. Special cases have out_valid high from cycle T+1.
- Operand prep:
  - divw: take bits [31:0], sign-extend if div_signed, else zero-extend, then compute at 32-bit width.
  - signed: divide magnitudes; q_neg = sign(a) XOR sign(b); r_neg = sign(a) (remainder takes the dividend's sign).
- Iteration: partial remainder register is width+1 bits. Each cycle: shift left, bring in the next dividend bit, trial-subtract |b|. If the result is non-negative, keep it and shift 1 into the quotient; else shift 0.
- Post-fixup: negate q if q_neg; negate r if r_neg. In divw, sign-extend bit 31 of both results to XLEN, regardless of div_signed (RISC-V DIVUW/REMUW rule).
- Special cases (w = active width):
  - Divisor == 0: quotient = all ones (w bits, then extended); remainder = dividend (w bits, then extended).
  - Signed, dividend == most-negative w-bit value, divisor == -1: quotient = dividend; remainder = 0.
  - Divisor == 0 takes precedence.
- Flush: in any state, flush=1 at an edge moves to IDLE. out_valid=0 the next cycle and any result is discarded. A div_valid in the same cycle as flush is not accepted.
- Simultaneous DONE with out_ready=1 and a new div_valid: the new request is not accepted that cycle (div_ready=0). It is accepted in the next IDLE cycle. No back-to-back issue.
- quotient/remainder registers retain their last value in IDLE. They are meaningful only while out_valid=1.

Decomposition:
- Package ysyx_22040632_div_pkg: state enum (IDLE, BUSY, DONE); iteration-counter width function clog2(XLEN+1); localparam W32 = 32.
- One natural sub-module, ysyx_22040632_div_signfix: combinational, parametrised by XLEN. It performs absolute value/negate, plus divw extension for both pre- and post-fixup. The FSM, counter and datapath stay in the top module.

Test Plan:
- XLEN=64 unsigned 100 / 7, out_ready=1 -> q=14, r=2; out_valid asserted exactly 65 cycles after accept, lasts 1 cycle; div_ready back the cycle after.
- Signed -7 / 2 -> q=0xFFFF_FFFF_FFFF_FFFD (-3), r=0xFFFF_FFFF_FFFF_FFFF (-1). Signed 7 / -2 -> q=-3, r=1.
- Divisor 0, dividend 0x1234 -> q=0xFFFF_FFFF_FFFF_FFFF, r=0x1234 at T+1. Signed 0x8000_0000_0000_0000 / -1 -> q=0x8000_0000_0000_0000, r=0 at T+1.
- divw, unsigned, dividend 0xDEAD_BEEF_8000_0000 / 0x2 -> q=0x0000_0000_4000_0000, r=0, latency 33. divw signed 0x8000_0000 / 0xFFFF_FFFF -> q=0xFFFF_FFFF_8000_0000, r=0.
- Flush asserted 10 cycles into BUSY -> div_ready=1 next cycle, out_valid never rises. A new request 50/5 then yields q=10, r=0.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid and results stable, div_ready=0 throughout. Release -> IDLE next cycle. rst during BUSY -> out_valid=0, div_ready=1 next cycle.
